// File: rtl/aud_rmm_burst_engine.sv
// AUD RMM burst sequencer: shifts TX FIFO words out onto the AUD bus or collects
// words from it into the RX FIFO, with 0-then-ones sync detection and a wait timeout.

module aud_rmm_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = (wp == rp);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end
endmodule

module aud_rmm_burst_engine #(
  parameter int DATA_W     = 32,
  parameter int BUS_W      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16,
  parameter int SYNC_HOLD  = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk_sys_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              dir_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_wr_i,
  output logic              tx_full_o,
  output logic [DATA_W-1:0] rx_data_o,
  input  logic              rx_rd_i,
  output logic              rx_empty_o,
  input  logic [BUS_W-1:0]  aud_data_i,
  output logic [BUS_W-1:0]  aud_data_o,
  output logic              aud_data_oe_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_timeout_o,
  output logic              err_ovf_o
);
  localparam int BEATS = DATA_W / BUS_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SHW   = $clog2(SYNC_HOLD + 1);
  localparam int TMW   = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0]   LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [SHW-1:0]   SYNC_LAST = SHW'(SYNC_HOLD - 1);
  localparam logic [TMW-1:0]   TMO_LAST  = TMW'(TIMEOUT - 1);
  localparam logic [BUS_W-1:0] BUS_ZERO  = '0;
  localparam logic [BUS_W-1:0] BUS_ONE   = BUS_W'(1);

  typedef enum logic [3:0] {
    IDLE, TX_LOAD, TX_SHIFT, TX_TURN, TX_ACK0, TX_ACK1, TX_TURN2,
    RX_HDR0, RX_HDR1, RX_SHIFT, RX_PUSH, DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [LEN_W-1:0]   remaining;
  logic [DATA_W-1:0]  tx_sh;
  logic [DATA_W-1:0]  rx_sh;
  logic [DATA_W-1:0]  tx_word;
  logic [BCW-1:0]     beat;
  logic [SHW-1:0]     sync_cnt;
  logic [TMW-1:0]     tmo;
  logic               tx_empty;
  logic               rx_full;
  logic               tx_pop;
  logic               rx_push;
  logic               word_ack;
  logic               in_wait;
  logic               tmo_hit;

  aud_rmm_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk_sys_i), .rst(rst_i), .push(tx_wr_i), .wdata(tx_data_i),
    .pop(tx_pop), .rdata(tx_word), .full(tx_full_o), .empty(tx_empty)
  );

  aud_rmm_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk_sys_i), .rst(rst_i), .push(rx_push), .wdata(rx_sh),
    .pop(rx_rd_i), .rdata(rx_data_o), .full(rx_full), .empty(rx_empty_o)
  );

  assign in_wait = (state == TX_ACK0) || (state == TX_ACK1) ||
                   (state == RX_HDR0) || (state == RX_HDR1);
  assign tmo_hit = in_wait && (tmo == TMO_LAST);

  assign aud_data_oe_o = (state == TX_SHIFT);
  assign aud_data_o    = aud_data_oe_o ? tx_sh[BUS_W-1:0] : '0;
  assign busy_o        = (state != IDLE);
  assign done_o        = (state == DONE);

  always_comb begin
    state_nx = state;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    word_ack = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) state_nx = DONE;
          else             state_nx = dir_i ? RX_HDR0 : TX_LOAD;
        end
      end
      TX_LOAD: begin
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          state_nx = TX_SHIFT;
        end
      end
      TX_SHIFT: if (beat == LAST_BEAT) state_nx = TX_TURN;
      TX_TURN:  state_nx = TX_ACK0;
      TX_ACK0, RX_HDR0: begin
        if (tmo_hit)                     state_nx = DONE;
        else if (aud_data_i == BUS_ZERO) state_nx = (state == TX_ACK0) ? TX_ACK1 : RX_HDR1;
      end
      TX_ACK1, RX_HDR1: begin
        // A repeated 0 keeps waiting for the ones; any other non-1 value restarts the sync.
        if (tmo_hit) begin
          state_nx = DONE;
        end else if (aud_data_i == BUS_ONE) begin
          if (sync_cnt == SYNC_LAST) begin
            word_ack = (state == TX_ACK1);
            state_nx = (state == TX_ACK1) ? TX_TURN2 : RX_SHIFT;
          end
        end else if (aud_data_i != BUS_ZERO) begin
          state_nx = (state == TX_ACK1) ? TX_ACK0 : RX_HDR0;
        end
      end
      TX_TURN2: state_nx = (remaining == '0) ? DONE : TX_LOAD;
      RX_SHIFT: if (beat == LAST_BEAT) state_nx = RX_PUSH;
      RX_PUSH: begin
        rx_push  = 1'b1;
        state_nx = (remaining == LEN_W'(1)) ? DONE : RX_HDR0;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      remaining     <= '0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      beat          <= '0;
      sync_cnt      <= '0;
      tmo           <= '0;
      err_timeout_o <= 1'b0;
      err_ovf_o     <= 1'b0;
    end else begin
      tmo <= in_wait ? tmo + TMW'(1) : '0;

      if (state == IDLE && start_i && len_i != '0) begin
        remaining     <= len_i;
        err_timeout_o <= 1'b0;
        err_ovf_o     <= 1'b0;
      end else if (word_ack || rx_push) begin
        remaining <= remaining - LEN_W'(1);
      end

      if (tx_pop)                 tx_sh <= tx_word;
      else if (state == TX_SHIFT) tx_sh <= tx_sh >> BUS_W;

      if (state == RX_SHIFT) rx_sh <= {aud_data_i, rx_sh[DATA_W-1:BUS_W]};

      if (state == TX_SHIFT || state == RX_SHIFT) beat <= beat + BCW'(1);
      else                                        beat <= '0;

      if ((state == TX_ACK1 || state == RX_HDR1) && aud_data_i == BUS_ONE)
        sync_cnt <= sync_cnt + SHW'(1);
      else
        sync_cnt <= '0;

      if (tmo_hit)              err_timeout_o <= 1'b1;
      if (rx_push && rx_full)   err_ovf_o     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_aud_rmm_burst_engine.sv
// Bench for aud_rmm_burst_engine: instance A (4-bit bus, depth 8) and instance B
// (8-bit bus, depth 2) share stimulus; use_b selects which one a scenario talks to.

module tb_aud_rmm_burst_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, dir;
  logic [15:0] len;
  logic [31:0] tx_data;
  logic        tx_wr_a, tx_wr_b, rx_rd_a, rx_rd_b;
  logic [7:0]  aud_in;

  logic        a_tx_full, a_rx_empty, a_oe, a_busy, a_done, a_err_to, a_err_ovf;
  logic [31:0] a_rx_data;
  logic [3:0]  a_aud;
  logic        b_tx_full, b_rx_empty, b_oe, b_busy, b_done, b_err_to, b_err_ovf;
  logic [31:0] b_rx_data;
  logic [7:0]  b_aud;

  int total = 0;
  int bad = 0;
  int a_done_n = 0, b_done_n = 0, a_oe_n = 0, b_oe_n = 0;
  logic use_b = 1'b0;

  logic [7:0]  beat_q[$];
  logic [31:0] rx_q[$];

  always #5 clk = ~clk;

  aud_rmm_burst_engine #(.DATA_W(32), .BUS_W(4), .FIFO_DEPTH(8), .LEN_W(16),
                         .SYNC_HOLD(2), .TIMEOUT(16)) dut_a (
    .clk_sys_i(clk), .rst_i(rst), .start_i(start_a), .dir_i(dir), .len_i(len),
    .tx_data_i(tx_data), .tx_wr_i(tx_wr_a), .tx_full_o(a_tx_full),
    .rx_data_o(a_rx_data), .rx_rd_i(rx_rd_a), .rx_empty_o(a_rx_empty),
    .aud_data_i(aud_in[3:0]), .aud_data_o(a_aud), .aud_data_oe_o(a_oe),
    .busy_o(a_busy), .done_o(a_done), .err_timeout_o(a_err_to), .err_ovf_o(a_err_ovf)
  );

  aud_rmm_burst_engine #(.DATA_W(32), .BUS_W(8), .FIFO_DEPTH(2), .LEN_W(16),
                         .SYNC_HOLD(2), .TIMEOUT(16)) dut_b (
    .clk_sys_i(clk), .rst_i(rst), .start_i(start_b), .dir_i(dir), .len_i(len),
    .tx_data_i(tx_data), .tx_wr_i(tx_wr_b), .tx_full_o(b_tx_full),
    .rx_data_o(b_rx_data), .rx_rd_i(rx_rd_b), .rx_empty_o(b_rx_empty),
    .aud_data_i(aud_in), .aud_data_o(b_aud), .aud_data_oe_o(b_oe),
    .busy_o(b_busy), .done_o(b_done), .err_timeout_o(b_err_to), .err_ovf_o(b_err_ovf)
  );

  wire        m_oe       = use_b ? b_oe       : a_oe;
  wire        m_done     = use_b ? b_done     : a_done;
  wire        m_busy     = use_b ? b_busy     : a_busy;
  wire        m_err_to   = use_b ? b_err_to   : a_err_to;
  wire        m_err_ovf  = use_b ? b_err_ovf  : a_err_ovf;
  wire        m_tx_full  = use_b ? b_tx_full  : a_tx_full;
  wire        m_rx_empty = use_b ? b_rx_empty : a_rx_empty;
  wire [31:0] m_rx_data  = use_b ? b_rx_data  : a_rx_data;
  wire [7:0]  m_aud      = use_b ? b_aud      : {4'h0, a_aud};

  always @(negedge clk) begin
    if (a_done === 1'b1) a_done_n++;
    if (b_done === 1'b1) b_done_n++;
    if (a_oe === 1'b1)   a_oe_n++;
    if (b_oe === 1'b1)   b_oe_n++;
  end

  task automatic push_tx(input logic [31:0] w, input bit accepted);
    int bw = use_b ? 8 : 4;
    if (accepted)
      for (int k = 0; k < 32 / bw; k++)
        beat_q.push_back(8'((w >> (k * bw)) & ((1 << bw) - 1)));
    tx_data = w;
    if (use_b) tx_wr_b = 1'b1; else tx_wr_a = 1'b1;
    @(negedge clk);
    tx_wr_a = 1'b0;
    tx_wr_b = 1'b0;
  endtask

  task automatic start_burst(input logic d, input logic [15:0] l);
    dir = d;
    len = l;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Target side of a write: checks each driven beat, then answers 0,0,1,1 (or never, when ack=0).
  task automatic serve_tx(input int n, input bit ack, input string tag);
    int bts = use_b ? 4 : 8;
    for (int w = 0; w < n; w++) begin
      int cnt = 0;
      int guard = 0;
      while (!m_oe && guard < 64) begin @(negedge clk); guard++; end
      total++;
      if (!m_oe) begin
        bad++;
        $display("FAIL %s_oe_wait word %0d: oe got %b, required 1", tag, w, m_oe);
        return;
      end
      while (m_oe && cnt < 64) begin
        logic [7:0] want;
        want = (beat_q.size() > 0) ? beat_q.pop_front() : 8'hxx;
        total++;
        if (m_aud !== want) begin
          bad++;
          $display("FAIL %s_beat word %0d beat %0d: got %h, required %h", tag, w, cnt, m_aud, want);
        end
        cnt++;
        @(negedge clk);
      end
      total++;
      if (cnt != bts) begin
        bad++;
        $display("FAIL %s_oe_len word %0d: got %0d cycles, required %0d", tag, w, cnt, bts);
      end
      if (!ack) begin
        aud_in = 8'hFF;
        return;
      end
      aud_in = 8'h00; @(negedge clk);
      aud_in = 8'h00; @(negedge clk);
      aud_in = 8'h01; @(negedge clk);
      aud_in = 8'h01; @(negedge clk);
      aud_in = 8'h00;
    end
  endtask

  task automatic rx_stream(input logic [31:0] w, input bit stored);
    int bw = use_b ? 8 : 4;
    aud_in = 8'h00; @(negedge clk);
    aud_in = 8'h00; @(negedge clk);
    aud_in = 8'h01; @(negedge clk);
    aud_in = 8'h01; @(negedge clk);
    for (int k = 0; k < 32 / bw; k++) begin
      aud_in = 8'((w >> (k * bw)) & ((1 << bw) - 1));
      @(negedge clk);
    end
    aud_in = 8'h00;
    if (stored) rx_q.push_back(w);
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (!m_done && g < 64) begin @(negedge clk); g++; end
    total++;
    if (!m_done) begin
      bad++;
      $display("FAIL %s_done_wait: done got %b, required 1", tag, m_done);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic drain_rx(input string tag);
    while (rx_q.size() > 0) begin
      logic [31:0] want;
      want = rx_q.pop_front();
      total++;
      if (m_rx_empty !== 1'b0 || m_rx_data !== want) begin
        bad++;
        $display("FAIL %s_rx_word: got %h empty=%b, required %h empty=0", tag, m_rx_data, m_rx_empty, want);
      end
      if (use_b) rx_rd_b = 1'b1; else rx_rd_a = 1'b1;
      @(negedge clk);
      rx_rd_a = 1'b0;
      rx_rd_b = 1'b0;
    end
    total++;
    if (m_rx_empty !== 1'b1) begin
      bad++;
      $display("FAIL %s_rx_drained: empty got %b, required 1", tag, m_rx_empty);
    end
  endtask

  task automatic check_flags(input string tag, input logic to, input logic ovf, input int dn, input int want_dn);
    total++;
    if (m_err_to !== to || m_err_ovf !== ovf || m_busy !== 1'b0 || dn != want_dn) begin
      bad++;
      $display("FAIL %s_end: got to=%b ovf=%b busy=%b dones=%0d, required to=%b ovf=%b busy=0 dones=%0d",
               tag, m_err_to, m_err_ovf, m_busy, dn, to, ovf, want_dn);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 0; start_b = 0; dir = 0; len = '0; tx_data = '0;
    tx_wr_a = 0; tx_wr_b = 0; rx_rd_a = 0; rx_rd_b = 0; aud_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({a_tx_full, a_rx_empty, a_oe, a_busy, a_done, a_err_to, a_err_ovf} !== 7'b0100000) begin
      bad++;
      $display("FAIL reset_a_flags: got %b, required 0100000",
               {a_tx_full, a_rx_empty, a_oe, a_busy, a_done, a_err_to, a_err_ovf});
    end
    total++;
    if ({b_tx_full, b_rx_empty, b_oe, b_busy, b_done, b_err_to, b_err_ovf} !== 7'b0100000) begin
      bad++;
      $display("FAIL reset_b_flags: got %b, required 0100000",
               {b_tx_full, b_rx_empty, b_oe, b_busy, b_done, b_err_to, b_err_ovf});
    end
    total++;
    if (a_rx_data !== 32'h0 || b_rx_data !== 32'h0 || a_aud !== 4'h0 || b_aud !== 8'h0) begin
      bad++;
      $display("FAIL reset_data: got rx %h/%h aud %h/%h, required all 0", a_rx_data, b_rx_data, a_aud, b_aud);
    end
  endtask

  task automatic test_len_zero();
    int d0 = a_done_n;
    int o0 = a_oe_n;
    use_b = 1'b0;
    start_burst(1'b0, 16'd0);
    total++;
    if (a_done !== 1'b1) begin
      bad++;
      $display("FAIL len0_done: got %b, required 1", a_done);
    end
    @(negedge clk);
    #1;
    total++;
    if (a_done_n - d0 != 1 || a_oe_n - o0 != 0 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL len0_quiet: got dones=%0d oe_cycles=%0d busy=%b, required 1 0 0",
               a_done_n - d0, a_oe_n - o0, a_busy);
    end
  endtask

  task automatic test_rx_empty_pop();
    use_b = 1'b0;
    rx_rd_a = 1'b1;
    @(negedge clk);
    rx_rd_a = 1'b0;
    @(negedge clk);
    total++;
    if (a_rx_empty !== 1'b1 || a_rx_data !== 32'h0) begin
      bad++;
      $display("FAIL rx_empty_pop: got empty=%b data=%h, required 1 0", a_rx_empty, a_rx_data);
    end
  endtask

  task automatic test_write_bus4();
    int d0;
    use_b = 1'b0;
    for (int i = 1; i <= 4; i++) push_tx({16'(i), 16'(i)}, 1'b1);
    d0 = a_done_n;
    start_burst(1'b0, 16'd4);
    serve_tx(4, 1'b1, "wr4");
    wait_done("wr4");
    check_flags("wr4", 1'b0, 1'b0, a_done_n - d0, 1);
    total++;
    if (beat_q.size() != 0) begin
      bad++;
      $display("FAIL wr4_beats_left: got %0d, required 0", beat_q.size());
    end
  endtask

  task automatic test_read_bus4();
    int d0 = a_done_n;
    use_b = 1'b0;
    start_burst(1'b1, 16'd2);
    rx_stream(32'h01234567, 1'b1);
    rx_stream(32'h89abcdef, 1'b1);
    wait_done("rd4");
    check_flags("rd4", 1'b0, 1'b0, a_done_n - d0, 1);
    drain_rx("rd4");
  endtask

  task automatic test_timeout();
    int n = 0;
    use_b = 1'b0;
    push_tx(32'hA5A55A5A, 1'b1);
    start_burst(1'b0, 16'd1);
    serve_tx(1, 1'b0, "tmo");
    @(negedge clk);
    while (!a_done && n < 100) begin @(negedge clk); n++; end
    total++;
    if (n != 16 || a_err_to !== 1'b1) begin
      bad++;
      $display("FAIL tmo_delay: got %0d cycles err=%b, required 16 err=1", n, a_err_to);
    end
    @(negedge clk);
    total++;
    if (a_err_to !== 1'b1 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL tmo_sticky: got err=%b busy=%b, required 1 0", a_err_to, a_busy);
    end
    start_burst(1'b1, 16'd1);
    total++;
    if (a_err_to !== 1'b0) begin
      bad++;
      $display("FAIL tmo_clear: got %b, required 0", a_err_to);
    end
    rx_stream(32'h13579bdf, 1'b1);
    wait_done("tmo_rd");
    drain_rx("tmo_rd");
  endtask

  task automatic test_tx_full_bus8();
    int d0;
    int o0;
    use_b = 1'b1;
    push_tx(32'h00010001, 1'b1);
    push_tx(32'h00020002, 1'b1);
    total++;
    if (b_tx_full !== 1'b1) begin
      bad++;
      $display("FAIL txfull_set: got %b, required 1", b_tx_full);
    end
    push_tx(32'hDEADBEEF, 1'b0);
    d0 = b_done_n;
    start_burst(1'b0, 16'd2);
    serve_tx(2, 1'b1, "wr8");
    wait_done("wr8");
    check_flags("wr8", 1'b0, 1'b0, b_done_n - d0, 1);
    o0 = b_oe_n;
    start_burst(1'b0, 16'd1);
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (b_oe_n - o0 != 0 || b_busy !== 1'b1 || b_err_to !== 1'b0) begin
      bad++;
      $display("FAIL wr8_stall: got oe_cycles=%0d busy=%b err=%b, required 0 1 0", b_oe_n - o0, b_busy, b_err_to);
    end
    push_tx(32'h0BADCAFE, 1'b1);
    serve_tx(1, 1'b1, "wr8_late");
    wait_done("wr8_late");
  endtask

  task automatic test_overflow();
    int d0 = b_done_n;
    use_b = 1'b1;
    start_burst(1'b1, 16'd3);
    rx_stream(32'hC0FFEE01, 1'b1);
    rx_stream(32'h12345678, 1'b1);
    rx_stream(32'hFEEDF00D, 1'b0);
    wait_done("ovf");
    check_flags("ovf", 1'b0, 1'b1, b_done_n - d0, 1);
    drain_rx("ovf");
  endtask

  task automatic test_reset_mid_shift();
    int g = 0;
    int o0;
    use_b = 1'b0;
    start_burst(1'b1, 16'd1);
    rx_stream(32'h0F0F0F0F, 1'b0);
    wait_done("rst_rd");
    for (int i = 0; i < 3; i++) push_tx(32'h11111111 * (i + 1), 1'b1);
    start_burst(1'b0, 16'd3);
    while (!a_oe && g < 64) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (a_oe !== 1'b0 || a_busy !== 1'b0 || a_rx_empty !== 1'b1 || a_tx_full !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: got oe=%b busy=%b rx_empty=%b tx_full=%b, required 0 0 1 0",
               a_oe, a_busy, a_rx_empty, a_tx_full);
    end
    beat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    o0 = a_oe_n;
    start_burst(1'b0, 16'd1);
    repeat (8) @(negedge clk);
    #1;
    total++;
    if (a_oe_n - o0 != 0 || a_busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_tx_empty: got oe_cycles=%0d busy=%b, required 0 1", a_oe_n - o0, a_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_len_zero();
    test_rx_empty_pop();
    test_write_bus4();
    test_read_bus4();
    test_timeout();
    test_tx_full_bus8();
    test_overflow();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
